// File: rtl/ibus_frame_ctrl_pkg.sv
// Shared constants for the FlySky iBUS receiver: header bytes and frame error codes.
package ibus_frame_ctrl_pkg;

  localparam logic [7:0] IBUS_HEADER0 = 8'h20;
  localparam logic [7:0] IBUS_HEADER1 = 8'h40;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/ibus_failsafe_timer.sv
// Saturating no-activity timer: counts clocks since the last kick and flags expiry at MaxCount.
// Expired comes out of reset high so consumers treat the link as lost until the first kick.
module ibus_failsafe_timer #(
  parameter int unsigned MaxCount = 1600000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic kick_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(MaxCount + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxCount);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expired_q, expired_d;

  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (kick_i) begin
      cnt_d     = '0;
      expired_d = 1'b0;
    end else begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CntMax) begin
        expired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/ibus_frame_ctrl.sv
// iBUS frame sequencer: header sync, channel capture, checksum check and atomic commit of
// good frames to a channel bank, plus inter-byte timeout and failsafe link-loss flag.
module ibus_frame_ctrl
  import ibus_frame_ctrl_pkg::*;
#(
  parameter int unsigned NumChannels  = 14,
  parameter logic [7:0]  Header0      = IBUS_HEADER0,
  parameter logic [7:0]  Header1      = IBUS_HEADER1,
  parameter int unsigned ClksPerGap   = 5560,
  parameter int unsigned FailsafeClks = 1600000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_data_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic [3:0]  ch_sel_i,
  output logic [15:0] ch_data_o,
  output logic        frame_valid_o,
  output logic        frame_error_o,
  output logic [1:0]  err_code_o,
  output logic [15:0] frame_count_o,
  output logic        link_lost_o
);

  localparam int unsigned ChIdxW = $clog2(NumChannels);
  localparam int unsigned GapW   = $clog2(ClksPerGap);
  localparam logic [ChIdxW-1:0] ChLast  = ChIdxW'(NumChannels - 1);
  localparam logic [GapW-1:0]   GapLast = GapW'(ClksPerGap - 1);

  typedef enum logic [2:0] {
    StIdle, StHdr1, StDataLo, StDataHi, StCsumLo, StCsumHi, StCommit
  } state_e;

  state_e              state_q;
  logic [15:0]         sum_q;
  logic [15:0]         cs_q;
  logic [ChIdxW-1:0]   ch_idx_q;
  logic [GapW-1:0]     gap_q;
  logic [15:0]         shadow_q    [NumChannels];
  logic [15:0]         committed_q [NumChannels];
  logic                frame_valid_q;
  logic                frame_error_q;
  logic [1:0]          err_code_q;
  logic [15:0]         frame_count_q;
  logic [15:0]         csum_total;
  logic                commit_pass;
  logic                hdr0_seen;

  assign csum_total  = sum_q + cs_q;
  assign commit_pass = (state_q == StCommit) && (csum_total == 16'hFFFF);
  assign hdr0_seen   = rx_data_ready_i && (rx_data_i == Header0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      sum_q         <= '0;
      cs_q          <= '0;
      ch_idx_q      <= '0;
      gap_q         <= '0;
      shadow_q      <= '{default: '0};
      committed_q   <= '{default: '0};
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= ERR_NONE;
      frame_count_q <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          gap_q <= '0;
          if (hdr0_seen) begin
            state_q  <= StHdr1;
            sum_q    <= {8'h00, Header0};
            ch_idx_q <= '0;
          end
        end
        StCommit: begin
          gap_q <= '0;
          if (commit_pass) begin
            committed_q   <= shadow_q;
            frame_valid_q <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
          end else begin
            frame_error_q <= 1'b1;
            err_code_q    <= ERR_CSUM;
          end
          // A byte landing in the commit cycle may already start the next frame.
          if (hdr0_seen) begin
            state_q  <= StHdr1;
            sum_q    <= {8'h00, Header0};
            ch_idx_q <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          if (rx_data_ready_i) begin
            gap_q <= '0;
            case (state_q)
              StHdr1: begin
                if (rx_data_i == Header1) begin
                  state_q <= StDataLo;
                  sum_q   <= sum_q + {8'h00, rx_data_i};
                end else if (rx_data_i == Header0) begin
                  sum_q <= {8'h00, Header0};
                end else begin
                  state_q <= StIdle;
                end
              end
              StDataLo: begin
                shadow_q[ch_idx_q][7:0] <= rx_data_i;
                sum_q   <= sum_q + {8'h00, rx_data_i};
                state_q <= StDataHi;
              end
              StDataHi: begin
                shadow_q[ch_idx_q][15:8] <= rx_data_i;
                sum_q <= sum_q + {8'h00, rx_data_i};
                if (ch_idx_q == ChLast) begin
                  state_q <= StCsumLo;
                end else begin
                  ch_idx_q <= ch_idx_q + 1'b1;
                  state_q  <= StDataLo;
                end
              end
              StCsumLo: begin
                cs_q[7:0] <= rx_data_i;
                state_q   <= StCsumHi;
              end
              StCsumHi: begin
                cs_q[15:8] <= rx_data_i;
                state_q    <= StCommit;
              end
              default: state_q <= StIdle;
            endcase
          end else if (gap_q == GapLast) begin
            // A stalled header is just noise; a stalled frame body is reported.
            gap_q   <= '0;
            state_q <= StIdle;
            if (state_q != StHdr1) begin
              frame_error_q <= 1'b1;
              err_code_q    <= ERR_TIMEOUT;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
      endcase
    end
  end

  ibus_failsafe_timer #(
    .MaxCount (FailsafeClks)
  ) u_failsafe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .kick_i    (commit_pass),
    .expired_o (link_lost_o)
  );

  assign ch_data_o     = ({28'd0, ch_sel_i} < NumChannels) ? committed_q[ch_sel_i] : 16'h0000;
  assign frame_valid_o = frame_valid_q;
  assign frame_error_o = frame_error_q;
  assign err_code_o    = err_code_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_ibus_frame_ctrl.sv
// Directed bench for ibus_frame_ctrl: table of whole-frame vectors plus hand-written
// sequences for timeout, failsafe expiry, mid-frame reset and frame counter wrap.
module tb_ibus_frame_ctrl;

  localparam int unsigned NumCh = 14;
  localparam int unsigned Gap   = 40;
  localparam int unsigned Fs    = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [3:0]  sel = 4'd0;
  logic [15:0] ch_data;
  logic        fv;
  logic        fe;
  logic [1:0]  code;
  logic [15:0] fcount;
  logic        ll;

  always #5 clk = ~clk;

  ibus_frame_ctrl #(
    .NumChannels  (NumCh),
    .Header0      (8'h20),
    .Header1      (8'h40),
    .ClksPerGap   (Gap),
    .FailsafeClks (Fs)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rx_data_ready_i (rdy),
    .rx_data_i       (data),
    .ch_sel_i        (sel),
    .ch_data_o       (ch_data),
    .frame_valid_o   (fv),
    .frame_error_o   (fe),
    .err_code_o      (code),
    .frame_count_o   (fcount),
    .link_lost_o     (ll)
  );

  typedef struct {
    logic [15:0] base;
    logic [7:0]  flip;
    logic        prefix;
    logic [3:0]  sel;
    logic        exp_ok;
    logic [1:0]  exp_code;
    logic [15:0] exp_data;
  } vec_t;

  vec_t        vecs [4];
  logic [7:0]  frame [32];
  logic [15:0] exp_count = 16'd0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected checksum: 0xFFFF minus the 16-bit sum of header and channel bytes.
  task automatic build_frame(input logic [15:0] base);
    logic [15:0] s;
    logic [15:0] v;
    logic [15:0] cs;
    frame[0] = 8'h20;
    frame[1] = 8'h40;
    s = 16'h0060;
    for (int i = 0; i < int'(NumCh); i++) begin
      v = base + 16'(i);
      frame[2 + 2 * i] = v[7:0];
      frame[3 + 2 * i] = v[15:8];
      s = s + {8'h00, v[7:0]} + {8'h00, v[15:8]};
    end
    cs = 16'hFFFF - s;
    frame[30] = cs[7:0];
    frame[31] = cs[15:8];
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int idle);
    rdy  = 1'b1;
    data = b;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bytes(input int count);
    for (int i = 0; i < count; i++) begin
      send_byte(frame[i], (i == count - 1) ? 0 : 1);
    end
  endtask

  // Result pulse is expected on the second sample after the last byte's pulse.
  task automatic finish_frame(input logic ok, input logic [1:0] exp_code);
    @(negedge clk);
    check("lat1_valid", fv, 1'b0);
    check("lat1_error", fe, 1'b0);
    @(negedge clk);
    check("frame_valid", fv, ok);
    check("frame_error", fe, !ok);
    check("err_code", code, exp_code);
    if (ok) begin
      exp_count = exp_count + 16'd1;
      check("link_lost_after_commit", ll, 1'b0);
    end
    check("frame_count", fcount, exp_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;
    vecs[0] = '{16'h05DC, 8'h00, 1'b0, 4'd3,  1'b1, 2'd0, 16'h05DF};
    vecs[1] = '{16'h0600, 8'h01, 1'b0, 4'd3,  1'b0, 2'd1, 16'h05DF};
    vecs[2] = '{16'h0800, 8'h00, 1'b1, 4'd13, 1'b1, 2'd1, 16'h080D};
    vecs[3] = '{16'h0900, 8'h00, 1'b0, 4'd14, 1'b1, 2'd1, 16'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", fv, 1'b0);
    check("rst_error", fe, 1'b0);
    check("rst_code", code, 2'd0);
    check("rst_count", fcount, 16'd0);
    check("rst_link_lost", ll, 1'b1);
    check("rst_ch_data", ch_data, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      @(posedge clk);
      #1;
      sel = vecs[v].sel;
      build_frame(vecs[v].base);
      frame[31] = frame[31] ^ vecs[v].flip;
      if (vecs[v].prefix) begin
        send_byte(8'h55, 1);
        send_byte(8'h20, 1);
      end
      send_bytes(32);
      finish_frame(vecs[v].exp_ok, vecs[v].exp_code);
      check("vec_ch_data", ch_data, vecs[v].exp_data);
    end

    // Failsafe: link lost exactly Fs clocks after the last commit.
    for (int n = 1; n <= int'(Fs); n++) begin
      @(negedge clk);
      if (n == int'(Fs) - 1) check("link_before_sat", ll, 1'b0);
      if (n == int'(Fs)) check("link_at_sat", ll, 1'b1);
    end
    @(posedge clk);
    #1;
    build_frame(16'h0A00);
    send_bytes(32);
    finish_frame(1'b1, 2'd1);

    // Inter-byte stall after 10 bytes.
    @(posedge clk);
    #1;
    build_frame(16'h0B00);
    send_bytes(10);
    hit = 0;
    for (int n = 1; n <= int'(Gap) + 20 && hit == 0; n++) begin
      @(negedge clk);
      if (fe) hit = n;
    end
    check("gap_timeout_cycles", hit, Gap + 1);
    check("gap_err_code", code, 2'd2);
    check("gap_count", fcount, exp_count);
    @(posedge clk);
    #1;
    sel = 4'd5;
    build_frame(16'h0C00);
    send_bytes(32);
    finish_frame(1'b1, 2'd2);
    check("after_gap_ch5", ch_data, 16'h0C05);

    // Reset in the middle of a frame.
    @(posedge clk);
    #1;
    sel = 4'd0;
    build_frame(16'h0D00);
    send_bytes(17);
    rst = 1'b1;
    #1;
    check("midrst_valid", fv, 1'b0);
    check("midrst_error", fe, 1'b0);
    check("midrst_code", code, 2'd0);
    check("midrst_count", fcount, 16'd0);
    check("midrst_link", ll, 1'b1);
    check("midrst_ch_data", ch_data, 16'h0000);
    exp_count = 16'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_bytes(32);
    finish_frame(1'b1, 2'd0);
    check("post_rst_ch0", ch_data, 16'h0D00);

    // Frame counter wrap.
    @(posedge clk);
    #1;
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count_q;
    @(negedge clk);
    check("preload_count", fcount, 16'hFFFF);
    exp_count = 16'hFFFF;
    @(posedge clk);
    #1;
    build_frame(16'h0E00);
    send_bytes(32);
    finish_frame(1'b1, 2'd0);
    check("wrap_count", fcount, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
